// File: rtl/mult_m_seq.sv
// Sequential signed n x n matrix multiplier (n = 2..DIM) built around one MAC, with a start/busy/done handshake.
// Define MULT_SAT_EN to saturate out-of-range elements; otherwise they wrap to the low WIDTH bits.
module mult_m_seq #(
    parameter int DIM   = 5,
    parameter int WIDTH = 8,
    parameter int SZW   = $clog2(DIM + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [SZW-1:0]             mat_size,
    input  logic [DIM*DIM*WIDTH-1:0]   lin,
    input  logic [DIM*DIM*WIDTH-1:0]   col,
    output logic [DIM*DIM*WIDTH-1:0]   n_out,
    output logic                       ovf,
    output logic                       busy,
    output logic                       done
);

    localparam int BW = DIM * DIM * WIDTH;
    localparam int AW = 2 * WIDTH + SZW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [SZW-1:0] N_MAX = SZW'(DIM);
    localparam logic [SZW-1:0] N_ONE = SZW'(1);
    localparam logic [SZW-1:0] N_TWO = SZW'(2);

    localparam logic signed [AW-1:0] MAX_V = AW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] MIN_V = ~MAX_V;

    logic [1:0]               state;
    logic [BW-1:0]            a_r;
    logic [BW-1:0]            b_r;
    logic [BW-1:0]            res_r;
    logic [SZW-1:0]           n_r;
    logic [SZW-1:0]           i_r;
    logic [SZW-1:0]           j_r;
    logic [SZW-1:0]           k_r;
    logic signed [AW-1:0]     acc;
    logic                     ovf_sh;

    logic [SZW-1:0]           n_eff;
    logic signed [WIDTH-1:0]  a_el;
    logic signed [WIDTH-1:0]  b_el;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]     sum;
    int                       res_pos;

    function automatic logic [WIDTH-1:0] elem(input logic [BW-1:0] bus,
                                              input logic [SZW-1:0] r,
                                              input logic [SZW-1:0] c);
        int pos;
        pos = (int'(r) * DIM + int'(c)) * WIDTH;
        return bus[BW-1-pos -: WIDTH];
    endfunction

    function automatic logic out_of_range(input logic signed [AW-1:0] s);
        return (s > MAX_V) || (s < MIN_V);
    endfunction

    function automatic logic [WIDTH-1:0] reduce(input logic signed [AW-1:0] s);
`ifdef MULT_SAT_EN
        if (s > MAX_V) return {1'b0, {(WIDTH-1){1'b1}}};
        if (s < MIN_V) return {1'b1, {(WIDTH-1){1'b0}}};
        return s[WIDTH-1:0];
`else
        return s[WIDTH-1:0];
`endif
    endfunction

    always_comb begin
        n_eff   = ((mat_size < N_TWO) || (mat_size > N_MAX)) ? N_MAX : mat_size;
        a_el    = elem(a_r, i_r, k_r);
        b_el    = elem(b_r, k_r, j_r);
        prod    = (2*WIDTH)'(a_el) * (2*WIDTH)'(b_el);
        sum     = acc + AW'(prod);
        res_pos = (int'(i_r) * DIM + int'(j_r)) * WIDTH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            res_r  <= '0;
            n_r    <= '0;
            i_r    <= '0;
            j_r    <= '0;
            k_r    <= '0;
            acc    <= '0;
            ovf_sh <= 1'b0;
            n_out  <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r    <= lin;
                        b_r    <= col;
                        n_r    <= n_eff;
                        i_r    <= '0;
                        j_r    <= '0;
                        k_r    <= '0;
                        acc    <= '0;
                        ovf_sh <= 1'b0;
                        // Cleared so elements outside the active n x n publish as zero.
                        res_r  <= '0;
                        busy   <= 1'b1;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (k_r == n_r - N_ONE) begin
                        res_r[BW-1-res_pos -: WIDTH] <= reduce(sum);
                        if (out_of_range(sum)) ovf_sh <= 1'b1;
                        acc <= '0;
                        k_r <= '0;
                        if (j_r == n_r - N_ONE) begin
                            j_r <= '0;
                            if (i_r == n_r - N_ONE) state <= S_DONE;
                            else i_r <= i_r + N_ONE;
                        end else begin
                            j_r <= j_r + N_ONE;
                        end
                    end else begin
                        acc <= sum;
                        k_r <= k_r + N_ONE;
                    end
                end
                S_DONE: begin
                    n_out <= res_r;
                    ovf   <= ovf_sh;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_m_seq.sv
// Randomised self-checking bench for mult_m_seq against a cycle-level behavioural model.
module tb_mult_m_seq;

    localparam int DIM   = 5;
    localparam int WIDTH = 8;
    localparam int SZW   = $clog2(DIM + 1);
    localparam int BW    = DIM * DIM * WIDTH;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [SZW-1:0] mat_size;
    logic [BW-1:0]  lin;
    logic [BW-1:0]  col;
    logic [BW-1:0]  n_out;
    logic           ovf;
    logic           busy;
    logic           done;

    int checks   = 0;
    int failures = 0;

    mult_m_seq #(.DIM(DIM), .WIDTH(WIDTH), .SZW(SZW)) dut (
        .clk(clk), .rst(rst), .start(start), .mat_size(mat_size),
        .lin(lin), .col(col), .n_out(n_out), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int eff_n(input logic [SZW-1:0] s);
        return (int'(s) < 2 || int'(s) > DIM) ? DIM : int'(s);
    endfunction

    function automatic int el(input logic [BW-1:0] bus, input int r, input int c);
        logic signed [WIDTH-1:0] v;
        v = bus[BW-1-(r*DIM+c)*WIDTH -: WIDTH];
        return int'(v);
    endfunction

    // Returns {ovf, result bus} for the given operands.
    function automatic logic [BW:0] ref_mult(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                             input logic [SZW-1:0] sz);
        logic [BW-1:0]    r;
        logic             o;
        logic [WIDTH-1:0] v;
        int               n;
        int               s;
        int               hi;
        int               lo;
        r  = '0;
        o  = 1'b0;
        n  = eff_n(sz);
        hi = (1 << (WIDTH - 1)) - 1;
        lo = -(1 << (WIDTH - 1));
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) s += el(a, i, k) * el(b, k, j);
                v = s[WIDTH-1:0];
                if (s > hi || s < lo) begin
                    o = 1'b1;
`ifdef MULT_SAT_EN
                    v = (s > hi) ? WIDTH'(hi) : WIDTH'(lo);
`endif
                end
                r[BW-1-(i*DIM+j)*WIDTH -: WIDTH] = v;
            end
        end
        return {o, r};
    endfunction

    function automatic logic [BW-1:0] fill(input logic [WIDTH-1:0] v);
        logic [BW-1:0] r;
        for (int e = 0; e < DIM*DIM; e++) r[BW-1-e*WIDTH -: WIDTH] = v;
        return r;
    endfunction

    function automatic logic [BW-1:0] rnd_bus();
        logic [BW-1:0] r;
        for (int e = 0; e < DIM*DIM; e++) r[BW-1-e*WIDTH -: WIDTH] = WIDTH'($urandom);
        return r;
    endfunction

    // Behavioural model: an accepted start publishes its product n^3+1 edges later.
    logic          m_busy;
    logic          m_done;
    logic          m_ovf;
    logic          p_ovf;
    logic [BW-1:0] m_nout;
    logic [BW-1:0] p_nout;
    int            m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_ovf  <= 1'b0;
            p_ovf  <= 1'b0;
            m_nout <= '0;
            p_nout <= '0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_nout <= p_nout;
                    m_ovf  <= p_ovf;
                end
            end else if (start) begin
                m_busy          <= 1'b1;
                m_cnt           <= eff_n(mat_size) ** 3 + 1;
                {p_ovf, p_nout} <= ref_mult(lin, col, mat_size);
            end
        end
    end

    task automatic chk(input string name, input logic [BW:0] act, input logic [BW:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("busy", {{BW{1'b0}}, busy}, {{BW{1'b0}}, m_busy});
        chk("done", {{BW{1'b0}}, done}, {{BW{1'b0}}, m_done});
        chk("ovf", {{BW{1'b0}}, ovf}, {{BW{1'b0}}, m_ovf});
        chk("n_out", {1'b0, n_out}, {1'b0, m_nout});
    endtask

    task automatic wait_done(input bit scramble, output int lat);
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            if (scramble) begin
                lin = rnd_bus();
                col = rnd_bus();
                mat_size = SZW'($urandom_range(0, 7));
                start = (c == 10);
            end
            tick();
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done within 400 cycles");
        end
    endtask

    task automatic run_op(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [SZW-1:0] sz,
                          input bit scramble, output int lat);
        lin = a;
        col = b;
        mat_size = sz;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(scramble, lat);
    endtask

    initial begin
        int            lat;
        logic [BW-1:0] exp3;
        logic [BW-1:0] exp4;
        logic [BW-1:0] ident;
        logic [BW-1:0] cval;

        exp3 = {{3{{3{8'hF7}}, 16'h0000}}, {10{8'h00}}};
`ifdef MULT_SAT_EN
        exp4 = fill(8'h7F);
`else
        exp4 = fill(8'h05);
`endif
        ident = '0;
        for (int d = 0; d < DIM; d++) ident[BW-1-(d*DIM+d)*WIDTH -: WIDTH] = 8'h01;

        rst = 1'b1; start = 1'b0; mat_size = '0; lin = '0; col = '0;
        tick();
        tick();
        chk("reset_n_out", {1'b0, n_out}, '0);
        chk("reset_flags", {{(BW-2){1'b0}}, ovf, busy, done}, '0);
        rst = 1'b0;
        tick();

        // 1: all 5s times all 1s
        run_op(fill(8'h05), fill(8'h01), 3'd5, 1'b0, lat);
        chk("t1_latency", (BW+1)'(lat), (BW+1)'(126));
        chk("t1_n_out", {1'b0, n_out}, {1'b0, {25{8'h19}}});
        chk("t1_model", {m_ovf, m_nout}, {1'b0, {25{8'h19}}});
        chk("t1_ovf", {{BW{1'b0}}, ovf}, '0);
        tick();
        chk("t1_busy_low", {{BW{1'b0}}, busy}, '0);

        // 2: identity on the left
        cval = rnd_bus();
        run_op(ident, cval, 3'd5, 1'b0, lat);
        chk("t2_identity", {ovf, n_out}, {1'b0, cval});

        // 3: n=3 negative values, padding zeros
        run_op(fill(8'hFD), fill(8'h01), 3'd3, 1'b0, lat);
        chk("t3_latency", (BW+1)'(lat), (BW+1)'(28));
        chk("t3_n_out", {ovf, n_out}, {1'b0, exp3});
        chk("t3_model", {m_ovf, m_nout}, {1'b0, exp3});

        // 4: overflow
        run_op(fill(8'h7F), fill(8'h7F), 3'd5, 1'b0, lat);
        chk("t4_n_out", {ovf, n_out}, {1'b1, exp4});
        chk("t4_model", {m_ovf, m_nout}, {1'b1, exp4});

        // 5: reset mid-operation
        lin = fill(8'h05); col = fill(8'h01); mat_size = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        #2 rst = 1'b1;
        tick();
        chk("t5_rst_n_out", {1'b0, n_out}, '0);
        chk("t5_rst_flags", {{(BW-2){1'b0}}, ovf, busy, done}, '0);
        tick();
        rst = 1'b0;
        tick();
        run_op(fill(8'hFD), fill(8'h01), 3'd3, 1'b0, lat);
        chk("t5_latency", (BW+1)'(lat), (BW+1)'(28));
        chk("t5_n_out", {ovf, n_out}, {1'b0, exp3});

        // 6: start and operand changes while busy are ignored; size 0 means DIM
        run_op(fill(8'h05), fill(8'h01), 3'd5, 1'b1, lat);
        chk("t6_latency", (BW+1)'(lat), (BW+1)'(126));
        chk("t6_n_out", {ovf, n_out}, {1'b0, {25{8'h19}}});
        tick();
        run_op(fill(8'h05), fill(8'h01), 3'd0, 1'b0, lat);
        chk("t6_size0_latency", (BW+1)'(lat), (BW+1)'(126));
        chk("t6_size0_n_out", {ovf, n_out}, {1'b0, {25{8'h19}}});

        // start held through completion relaunches on the first IDLE cycle
        lin = fill(8'h7F); col = fill(8'h7F); mat_size = 3'd2; start = 1'b1;
        tick();
        wait_done(1'b0, lat);
        start = 1'b1;
        chk("b2b_latency", (BW+1)'(lat), (BW+1)'(9));
        lin = fill(8'hFD); col = fill(8'h01); mat_size = 3'd3;
        tick();
        start = 1'b0;
        wait_done(1'b0, lat);
        chk("b2b_latency2", (BW+1)'(lat), (BW+1)'(28));
        chk("b2b_n_out", {ovf, n_out}, {1'b0, exp3});

        // randomised operations with random gaps
        for (int t = 0; t < 10; t++) begin
            repeat ($urandom_range(0, 3)) tick();
            run_op(rnd_bus(), rnd_bus(), SZW'($urandom_range(0, 7)), 1'b1, lat);
        end
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
